// File: rtl/set_job_driver.sv
// set_job_driver: initiator for the SET lattice-point counter's en/busy/valid handshake.
//
// Jobs written by the host are queued in a small FIFO. They are issued to SET one at a time.
// Each returned candidate is presented on a valid/ready result port. The result carries a tag
// equal to the job's issue order.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   job_*              host push side: job_wr strobe, central/radius/mode payload,
//                      job_full level, job_ovf / job_err one-cycle drop pulses
//   set_*              SET side: en/central/radius/mode out; busy/valid/candidate in
//   res_*              result port: valid/ready handshake, candidate, tag, timeout error
//   idle               FSM idle, FIFO empty and no result pending
//
// Optional feature: define SET_JOB_TIMEOUT_EN to post an error result when SET does not
// answer within TIMEOUT_CYC cycles of WAIT_VALID entry. When it is undefined, res_err is tied 0.

module set_job_driver #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_wr,
    input  logic [23:0]      job_central,
    input  logic [11:0]      job_radius,
    input  logic [1:0]       job_mode,
    output logic             job_full,
    output logic             job_ovf,
    output logic             job_err,
    output logic             set_en,
    output logic [23:0]      set_central,
    output logic [11:0]      set_radius,
    output logic [1:0]       set_mode,
    input  logic             set_busy,
    input  logic             set_valid,
    input  logic [7:0]       set_candidate,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_candidate,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             idle
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned JW = 24 + 12 + 2;
    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitValid, StWaitDone} state_e;

    state_e             state_q, state_d;
    logic [JW-1:0]      mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               set_en_q, set_en_d;
    logic [23:0]        set_central_q, set_central_d;
    logic [11:0]        set_radius_q, set_radius_d;
    logic [1:0]         set_mode_q, set_mode_d;
    logic [TAG_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               res_valid_q, res_valid_d;
    logic [7:0]         res_cand_q, res_cand_d;
    logic               job_ovf_q, job_ovf_d;
    logic               job_err_q, job_err_d;
`ifdef SET_JOB_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);
    logic               res_err_q, res_err_d;
    logic [7:0]         tmo_cnt_q, tmo_cnt_d;
`endif

    logic [AW:0]   fifo_cnt;
    logic          fifo_empty, fifo_full;
    logic          go, push_ok, mode_bad;
    logic [JW-1:0] head;

    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DepthCnt);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign mode_bad   = (job_mode == 2'd3);

    // Issue only with SET quiet and the result slot free (or being freed this cycle).
    assign go      = (state_q == StIdle) && !fifo_empty && !set_busy &&
                     (!res_valid_q || res_ready);
    // A full FIFO still accepts a push in the cycle that pops.
    assign push_ok = job_wr && !mode_bad && (!fifo_full || go);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q + (AW + 1)'(push_ok);
        rd_ptr_d      = rd_ptr_q + (AW + 1)'(go);
        set_en_d      = 1'b0;
        set_central_d = set_central_q;
        set_radius_d  = set_radius_q;
        set_mode_d    = set_mode_q;
        issue_cnt_d   = issue_cnt_q;
        tag_d         = tag_q;
        res_valid_d   = res_valid_q && !res_ready;
        res_cand_d    = res_cand_q;
        job_ovf_d     = job_wr && !mode_bad && fifo_full && !go;
        job_err_d     = job_wr && mode_bad;
`ifdef SET_JOB_TIMEOUT_EN
        res_err_d     = res_err_q;
        tmo_cnt_d     = tmo_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    {set_central_d, set_radius_d, set_mode_d} = head;
                    tag_d    = issue_cnt_q;
                    set_en_d = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                issue_cnt_d = issue_cnt_q + TAG_W'(1);
`ifdef SET_JOB_TIMEOUT_EN
                tmo_cnt_d   = '0;
`endif
                state_d     = StWaitValid;
            end
            StWaitValid: begin
                if (set_valid) begin
                    res_valid_d = 1'b1;
                    res_cand_d  = set_candidate;
`ifdef SET_JOB_TIMEOUT_EN
                    res_err_d   = 1'b0;
`endif
                    state_d     = StWaitDone;
                end
`ifdef SET_JOB_TIMEOUT_EN
                else if (tmo_cnt_q == TmoLast) begin
                    res_valid_d = 1'b1;
                    res_cand_d  = '0;
                    res_err_d   = 1'b1;
                    state_d     = StWaitDone;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            StWaitDone: begin
                // SET keeps busy one cycle past valid; a late valid here is ignored.
                if (!set_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            set_en_q      <= 1'b0;
            set_central_q <= '0;
            set_radius_q  <= '0;
            set_mode_q    <= '0;
            issue_cnt_q   <= '0;
            tag_q         <= '0;
            res_valid_q   <= 1'b0;
            res_cand_q    <= '0;
            job_ovf_q     <= 1'b0;
            job_err_q     <= 1'b0;
`ifdef SET_JOB_TIMEOUT_EN
            res_err_q     <= 1'b0;
            tmo_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            set_en_q      <= set_en_d;
            set_central_q <= set_central_d;
            set_radius_q  <= set_radius_d;
            set_mode_q    <= set_mode_d;
            issue_cnt_q   <= issue_cnt_d;
            tag_q         <= tag_d;
            res_valid_q   <= res_valid_d;
            res_cand_q    <= res_cand_d;
            job_ovf_q     <= job_ovf_d;
            job_err_q     <= job_err_d;
`ifdef SET_JOB_TIMEOUT_EN
            res_err_q     <= res_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {job_central, job_radius, job_mode};
    end

    assign job_full      = fifo_full;
    assign job_ovf       = job_ovf_q;
    assign job_err       = job_err_q;
    assign set_en        = set_en_q;
    assign set_central   = set_central_q;
    assign set_radius    = set_radius_q;
    assign set_mode      = set_mode_q;
    assign res_valid     = res_valid_q;
    assign res_candidate = res_cand_q;
    assign res_tag       = tag_q;
`ifdef SET_JOB_TIMEOUT_EN
    assign res_err       = res_err_q;
`else
    assign res_err       = 1'b0;
`endif
    assign idle          = (state_q == StIdle) && fifo_empty && !res_valid_q;

endmodule

// File: tb/tb_set_job_driver.sv
// Directed testbench for set_job_driver with a behavioural SET lattice counter attached.
module tb_set_job_driver;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned TAG_W       = 4;
    localparam int unsigned TIMEOUT_CYC = 80;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             job_wr = 1'b0;
    logic [23:0]      job_central = '0;
    logic [11:0]      job_radius = '0;
    logic [1:0]       job_mode = '0;
    logic             job_full, job_ovf, job_err;
    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             set_busy, set_valid;
    logic [7:0]       set_candidate;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [7:0]       res_candidate;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic             idle;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int en_cyc = 0;
    int busy_viol = 0;
    int ovf_cnt = 0;
    int e0, o0, acc_cyc;
    logic stub_mute = 1'b0;
    logic [7:0] m_ctr;

    set_job_driver #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .job_wr(job_wr), .job_central(job_central), .job_radius(job_radius),
        .job_mode(job_mode), .job_full(job_full), .job_ovf(job_ovf), .job_err(job_err),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
        .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
        .set_candidate(set_candidate), .res_valid(res_valid), .res_ready(res_ready),
        .res_candidate(res_candidate), .res_tag(res_tag), .res_err(res_err), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Points of the 16x16 lattice inside circle A, A and B, or exactly one of them.
    function automatic logic [7:0] lattice(input logic [23:0] c, input logic [11:0] r,
                                           input logic [1:0] m);
        int ax = int'(c[23:20]);
        int ay = int'(c[19:16]);
        int bx = int'(c[15:12]);
        int by = int'(c[11:8]);
        int ar = int'(r[11:8]);
        int br = int'(r[7:4]);
        int n = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                logic ina, inb, hit;
                ina = ((x - ax) * (x - ax) + (y - ay) * (y - ay)) <= ar * ar;
                inb = ((x - bx) * (x - bx) + (y - by) * (y - by)) <= br * br;
                hit = (m == 2'd0) ? ina : (m == 2'd1) ? (ina && inb) : (ina ^ inb);
                if (hit) n++;
            end
        end
        return 8'(n);
    endfunction

    // SET model: busy from the cycle after en, valid 64 cycles later, busy one more cycle.
    always @(posedge clk) begin
        if (rst) begin
            set_busy <= 1'b0;
            set_valid <= 1'b0;
            set_candidate <= '0;
            m_ctr <= '0;
        end else if (!set_busy) begin
            set_valid <= 1'b0;
            if (set_en) begin
                set_busy <= 1'b1;
                m_ctr <= '0;
                set_candidate <= lattice(set_central, set_radius, set_mode);
            end
        end else begin
            m_ctr <= m_ctr + 8'd1;
            set_valid <= (m_ctr == 8'd63) && !stub_mute;
            if (m_ctr == 8'd65) set_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (set_en) begin
            en_cnt++;
            en_cyc = cyc;
            if (set_busy) busy_viol++;
        end
        if (job_ovf) ovf_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        job_wr = 1'b1;
        job_central = c;
        job_radius = r;
        job_mode = m;
        step();
        job_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_res(input int budget);
        int n = 0;
        while (!res_valid && n < budget) begin
            step();
            n++;
        end
        chk("res_valid_within_budget", res_valid, 1);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        acc_cyc = cyc;
        step();
        res_ready = 1'b0;
    endtask

    logic [7:0] exp_cand [3] = '{8'd13, 8'd0, 8'd13};

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("reset_outputs", {job_full, job_ovf, job_err, set_en, set_central, set_radius,
                              set_mode, res_valid, res_candidate, res_tag, res_err}, '0);
        chk("reset_idle", idle, 1);
        rst = 1'b0;
        step();

        // Single job, nominal latency
        e0 = en_cnt;
        push(24'h440000, 12'h200, 2'd0);
        wait_res(150);
        chk("single_latency", cyc - en_cyc, 66);
        chk("single_cand", res_candidate, 13);
        chk("single_tag", res_tag, 0);
        chk("single_err", res_err, 0);
        chk("single_en_pulses", en_cnt - e0, 1);
        chk("set_bus_held", {set_central, set_radius, set_mode}, {24'h440000, 12'h200, 2'd0});
        repeat (10) step();
        chk("result_held", {res_valid, res_candidate}, {1'b1, 8'd13});
        accept();
        chk("result_cleared", res_valid, 0);

        // Three jobs back-to-back
        do_reset();
        push(24'h444400, 12'h220, 2'd1);
        push(24'h444400, 12'h220, 2'd2);
        push(24'h440000, 12'h200, 2'd0);
        for (int i = 0; i < 3; i++) begin
            wait_res(300);
            chk($sformatf("b2b_cand%0d", i), res_candidate, exp_cand[i]);
            chk($sformatf("b2b_tag%0d", i), res_tag, i);
            accept();
        end
        chk("en_while_busy", busy_viol, 0);

        // Unconsumed result blocks the next issue
        do_reset();
        e0 = en_cnt;
        push(24'h440000, 12'h200, 2'd0);
        push(24'h444400, 12'h220, 2'd2);
        wait_res(150);
        repeat (100) step();
        chk("blocked_en_count", en_cnt - e0, 1);
        chk("blocked_result_stable", {res_valid, res_candidate, res_tag},
            {1'b1, 8'd13, 4'd0});
        accept();
        wait_res(300);
        chk("second_en_after_accept", en_cyc >= acc_cyc, 1);
        chk("second_tag", res_tag, 1);
        chk("second_cand", res_candidate, 0);
        chk("second_en_count", en_cnt - e0, 2);
        accept();

        // FIFO fill, overflow and mode-3 rejection
        do_reset();
        e0 = en_cnt;
        o0 = ovf_cnt;
        for (int i = 0; i < int'(DEPTH) + 1; i++) push(24'h440000, 12'h200, 2'd0);
        chk("fill_first_popped", en_cnt - e0, 1);
        chk("fill_full", job_full, 1);
        chk("fill_no_ovf", ovf_cnt - o0, 0);
        push(24'h440000, 12'h200, 2'd0);
        chk("ovf_pulse", job_ovf, 1);
        step();
        chk("ovf_single_pulse", {job_ovf, 32'(ovf_cnt - o0)}, {1'b0, 32'd1});
        push(24'h440000, 12'h200, 2'd3);
        chk("err_pulse_full", job_err, 1);
        step();
        chk("err_single_pulse", job_err, 0);
        chk("still_full", job_full, 1);
        do_reset();
        e0 = en_cnt;
        push(24'h440000, 12'h200, 2'd3);
        chk("err_pulse_empty", job_err, 1);
        chk("mode3_not_queued", idle, 1);
        repeat (5) step();
        chk("mode3_no_issue", en_cnt - e0, 0);

        // Reset during WAIT_VALID
        do_reset();
        e0 = en_cnt;
        push(24'h440000, 12'h200, 2'd0);
        for (int n = 0; n < 20 && en_cnt == e0; n++) step();
        chk("mid_job_issued", en_cnt - e0, 1);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_outputs", {job_full, job_ovf, job_err, set_en, set_central, set_radius,
                               set_mode, res_valid, res_candidate, res_tag, res_err}, '0);
        chk("midrst_idle", idle, 1);
        push(24'h440000, 12'h200, 2'd0);
        wait_res(150);
        chk("post_rst_tag", res_tag, 0);
        chk("post_rst_cand", res_candidate, 13);
        chk("post_rst_latency", cyc - en_cyc, 66);
        accept();

`ifdef SET_JOB_TIMEOUT_EN
        // SET never answers
        do_reset();
        stub_mute = 1'b1;
        push(24'h440000, 12'h200, 2'd0);
        wait_res(200);
        chk("tmo_latency", cyc - en_cyc, TIMEOUT_CYC + 1);
        chk("tmo_result", {res_err, res_candidate, res_tag}, {1'b1, 8'd0, 4'd0});
        accept();
        stub_mute = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
